// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// Multi-cycle unsigned 32x32 multiplier that borrows the core's 32-bit ALU
// adder. A radix-2 shift-add loop issues one ALU ADD per cycle for 32 cycles,
// then pulses done for one cycle with the 64-bit product on
// product_hi/product_lo.
//
// Ports:
//   clk, rst            core clock (rising edge), asynchronous active-high reset
//   start, op_a, op_b   request strobe and operands (multiplicand, multiplier)
//   alu_a, alu_b        ALU operands: partial-product high word, multiplicand
//   alu_ctrl            ALU control, fixed at ADD (3'b000)
//   alu_result          ALU sum, combinational from alu_a/alu_b
//   alu_carry           ALU carry-out, combinational from alu_a/alu_b
//   busy, done          busy in RUN and DONE; done is a one-cycle pulse
//   product_hi/lo       64-bit product, valid from done until the next start
//
// Configuration macro:
//   ALU_MUL_SEQ_ZERO_SKIP_EN  when defined, a zero operand skips RUN and
//                             completes in one cycle with a zero product.
module alu_mul_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    output logic        busy,
    output logic        done,
    output logic [31:0] product_hi,
    output logic [31:0] product_lo
);

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned LAST  = W - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [W-1:0]       mcand;
    logic [W-1:0]       acc;
    logic [W-1:0]       mplr;
    logic [CNT_W-1:0]   cnt;
    logic               zero_op_c;

    // Early-out qualifier for a zero operand
`ifdef ALU_MUL_SEQ_ZERO_SKIP_EN
    assign zero_op_c = (op_a == '0) || (op_b == '0);
`else
    assign zero_op_c = 1'b0;
`endif

    // ALU is driven straight from the state registers
    assign alu_a      = acc;
    assign alu_b      = mcand;
    assign alu_ctrl   = 3'b000;
    assign product_hi = acc;
    assign product_lo = mplr;

    // Sequencer: load, 32 shift-add iterations, one-cycle done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            mcand <= '0;
            acc   <= '0;
            mplr  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= op_a;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        if (zero_op_c) begin
                            mplr  <= '0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            mplr  <= op_b;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Carry-out lands in acc[31] after the shift, keeping all 64 bits
                    if (mplr[0]) begin
                        {acc, mplr} <= {alu_carry, alu_result, mplr[W-1:1]};
                    end else begin
                        {acc, mplr} <= {1'b0, acc, mplr[W-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(LAST)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a behavioural 32-bit ALU adder.
module tb_alu_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        busy;
    logic        done;
    logic [31:0] product_hi;
    logic [31:0] product_lo;
    logic [32:0] alu_sum;

    int n_cmp = 0;
    int n_err = 0;

`ifdef ALU_MUL_SEQ_ZERO_SKIP_EN
    localparam int ZERO_DONE_CYC = 1;
`else
    localparam int ZERO_DONE_CYC = 33;
`endif

    alu_mul_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .busy       (busy),
        .done       (done),
        .product_hi (product_hi),
        .product_lo (product_lo)
    );

    // Core ALU adder model
    assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_result = alu_sum[31:0];
    assign alu_carry  = alu_sum[32];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance into the next cycle; sample/drive 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a multiply in cycle 0, optionally pulse start again in cycles i1/i2
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int exp_cyc, input int i1, input int i2);
        int          ndone;
        int          done_cyc;
        logic [31:0] hi_at_done;
        logic [31:0] lo_at_done;
        logic        ctrl_bad;
        logic        aluop_bad;
        ndone      = 0;
        done_cyc   = -1;
        hi_at_done = 'x;
        lo_at_done = 'x;
        ctrl_bad   = 1'b0;
        aluop_bad  = 1'b0;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start = (c == i1) || (c == i2);
            if (start) begin
                op_a = 32'd2;
                op_b = 32'd2;
            end
            if (alu_ctrl !== 3'b000) ctrl_bad = 1'b1;
            if (alu_a !== product_hi) aluop_bad = 1'b1;
            if (busy && (alu_b !== a)) aluop_bad = 1'b1;
            if (c == 1) check({tag, "_busy_c1"}, 64'(busy), 64'd1);
            if (c == exp_cyc + 1) check({tag, "_busy_fall"}, 64'(busy), 64'd0);
            if (done === 1'b1) begin
                ndone++;
                done_cyc   = c;
                hi_at_done = product_hi;
                lo_at_done = product_lo;
            end
        end
        start = 1'b0;
        check({tag, "_done_count"}, 64'(ndone), 64'd1);
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
        check({tag, "_product_at_done"}, {hi_at_done, lo_at_done}, {exp_hi, exp_lo});
        check({tag, "_product_held"}, {product_hi, product_lo}, {exp_hi, exp_lo});
        check({tag, "_alu_ctrl"}, 64'(ctrl_bad), 64'd0);
        check({tag, "_alu_operands"}, 64'(aluop_bad), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_product"}, {product_hi, product_lo}, 64'd0);
        check({tag, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
        check({tag, "_alu_ctrl"}, 64'(alu_ctrl), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        run_mul("mul_3x5", 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 33, -1, -1);
        run_mul("mul_carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, -1, -1);
        run_mul("lockout", 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A, 33, 5, 33);

        // Asynchronous reset in cycle 10 of a running multiply
        start = 1'b1;
        op_a  = 32'h1234_5678;
        op_b  = 32'h9ABC_DEF0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
        end
        check("midrun_busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_all_zero("midrun_rst");
        tick();
        check_all_zero("midrun_rst_held");
        rst = 1'b0;
        run_mul("after_rst", 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080, 33, -1, -1);

        run_mul("zero_op", 32'd0, 32'h0000_1234, 32'h0, 32'h0, ZERO_DONE_CYC, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
